dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Synchronous data-memory target that answers the core's load/store requests over a valid/ready request channel and a valid/ready response channel. It replaces the core's bare combinational data-memory port so the core can be extended to multi-cycle memory accesses. It holds a word-addressed RAM, inserts programmable wait states, applies byte-lane writes, and flags misaligned or out-of-range accesses. At most one request is in flight.

Parameters:
WORDS, 8, number of 32-bit words; must be a power of two ≥ 2.
WAIT_STATES, 1, idle cycles inserted between request accept and the array access; 0..15.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_be  input  4  store byte enables; bit i enables wdata[8i+7:8i]; ignored for loads.
req_wdata  input  32  store data.
rsp_valid  output  1  response present.
rsp_ready  input  1  core accepts the response.
rsp_rdata  output  32  load data; 0 for stores and errors.
rsp_err  output  1  access rejected.
busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP.
- Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; wait counter=0. RAM contents are not reset. If reset asserts before the ACCESS edge, an in-flight store is dropped and its RAM word is unchanged.
- IDLE: req_ready=1. Accept on req_valid && req_ready. Latch we, addr, be, and wdata. Next state is WAIT with counter=WAIT_STATES. If WAIT_STATES=0, next state is ACCESS.
- WAIT: counter decrements each cycle. When counter==1, next state is ACCESS.
- ACCESS (one cycle):
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] ≥ WORDS).
  - Index = addr[2 +: log2(WORDS)].
  - Store with no error: write each lane whose be bit is set; be=4'b0000 is a legal no-op.
  - Load with no error: register the full word into rsp_rdata.
  - rsp_err is registered. Next state is RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready. On rsp_valid && rsp_ready: rsp_valid=0, rsp_rdata=0, rsp_err=0, next state IDLE. The next request can be accepted no earlier than the following cycle.
- req_ready=0 in WAIT, ACCESS, and RESP. No request pipelining. Request inputs are sampled only at accept.
- Latency: request accepted at the edge ending cycle N → rsp_valid first high in cycle N+WAIT_STATES+2 (N+2 when WAIT_STATES=0).
- Read-after-write: a load following a store to the same word returns the stored merged data.
- Back-pressure: rsp_ready low for any number of cycles holds the response; no timeout.

Optional Feature:
DMEM_STATS_EN:
- Defined: adds outputs stat_loads[15:0] and stat_stores[15:0], plus stat_errs[7:0].
  - Counters increment on the rsp_valid && rsp_ready handshake, according to the completed request type and error flag.
  - Load/store counters count only error-free accesses.
  - Counters saturate at all-ones and clear on reset.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- WAIT_STATES=1, store addr 0x04, be=4'hF, wdata=0xDEADBEEF, rsp_ready=1 → rsp_valid 3 cycles after accept, rsp_err=0. Load 0x04 → rsp_rdata=0xDEADBEEF.
- Word 2 holds 0x11223344; store addr 0x08, be=4'b0101, wdata=0xAABBCCDD → a subsequent load of 0x08 returns 0x11BB33DD.
- Load addr 0x06 (misaligned) → rsp_err=1, rsp_rdata=0. Store addr 0x20 with WORDS=8 → rsp_err=1, and all 8 words are unchanged.
- WAIT_STATES=0, hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata, and rsp_err stay constant, and req_ready=0 throughout. Assert rsp_ready → the next cycle has state IDLE and req_ready=1.
- Word 3 holds 0x55; issue store 0x0C, wdata 0x77; assert reset during WAIT → outputs return to reset values immediately. After release, a load of 0x0C returns 0x55.
- With DMEM_STATS_EN defined: 3 good loads, 2 good stores, and 1 error → stat_loads=3, stat_stores=2, stat_errs=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory target with valid/ready request and response channels,
// programmable wait states and byte-lane stores. Define DMEM_STATS_EN to add completion counters.
module dmem_responder #(
    parameter int WORDS       = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [7:0]  stat_errs
`endif
);

    localparam int          IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] LP_WORDS = 32'(WORDS);
    localparam logic [3:0]  LP_WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;

    logic         r_we;
    logic [31:0]  r_addr;
    logic [3:0]   r_be;
    logic [31:0]  r_wdata;
    logic [31:0]  r_rsp_rdata;
    logic         r_rsp_err;

    logic             w_accept;
    logic             w_rsp_fire;
    logic             w_err;
    logic             w_write_en;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;
    assign w_err      = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= LP_WORDS);
    assign w_idx      = r_addr[2 +: IDX_W];
    assign w_write_en = (r_state == S_ACCESS) && r_we && !w_err;

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;

    // One RAM per byte lane so each lane's enable is an independent write port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [WORDS];

            always_ff @(posedge clk) begin
                if (w_write_en && r_be[gi]) begin
                    r_lane[w_idx] <= r_wdata[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_lane[w_idx];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_next   = LP_WS;
                    w_state_next = (LP_WS == 4'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_be    <= req_be;
                r_wdata <= req_wdata;
            end
            // Response data is zero for stores and rejected accesses.
            if (r_state == S_ACCESS) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (!r_we && !w_err) ? w_rd_word : 32'd0;
            end else if (w_rsp_fire) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] r_stat_loads;
    logic [15:0] r_stat_stores;
    logic [7:0]  r_stat_errs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_loads  <= 16'd0;
            r_stat_stores <= 16'd0;
            r_stat_errs   <= 8'd0;
        end else if (w_rsp_fire) begin
            if (r_rsp_err) begin
                if (r_stat_errs != 8'hFF) r_stat_errs <= r_stat_errs + 8'd1;
            end else if (r_we) begin
                if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
            end else begin
                if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
            end
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_errs   = r_stat_errs;
`endif

endmodule
